// File: rtl/param_seq_detect_if.sv
// rtl/param_seq_detect_if.sv - serial data, configuration and status bundle for param_seq_detect
interface param_seq_detect_if #(
  parameter int PAT_W = 16,
  parameter int LEN_W = 5,
  parameter int CNT_W = 8
);
  logic             seed;
  logic             seed_valid;
  logic             cfg_load;
  logic [PAT_W-1:0] cfg_pattern;
  logic [LEN_W-1:0] cfg_len;
  logic             cfg_overlap;
  logic             cnt_clr;
  logic             o_done;
  logic [CNT_W-1:0] o_match_cnt;

  modport master (
    output seed, seed_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    input  o_done, o_match_cnt
  );

  modport slave (
    input  seed, seed_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, cnt_clr,
    output o_done, o_match_cnt
  );
endinterface

// File: rtl/param_seq_detect.sv
// rtl/param_seq_detect.sv - programmable serial bit-pattern detector with saturating match counter
module param_seq_detect #(
  parameter int               PAT_W       = 16,
  parameter int               LEN_W       = 5,
  parameter int               CNT_W       = 8,
  parameter logic [PAT_W-1:0] DEF_PATTERN = 'h006E,
  parameter int               DEF_LEN     = 8
) (
  input logic               clk,
  input logic               rst,
  param_seq_detect_if.slave bus
);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(PAT_W);
  localparam logic [LEN_W-1:0] RST_LEN = LEN_W'(DEF_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [PAT_W-1:0] pat_q;
  logic [LEN_W-1:0] len_q;
  logic             ovl_q;
  logic [PAT_W-1:0] sr;
  logic [LEN_W-1:0] fill;
  logic             done_q;
  logic [CNT_W-1:0] cnt_q;

  logic [PAT_W-1:0] sr_n;
  logic [LEN_W-1:0] fill_n;
  logic [PAT_W-1:0] len_mask;
  logic [LEN_W-1:0] cfg_len_clamped;
  logic             match;

  always_comb begin
    sr_n   = (sr << 1) | PAT_W'(bus.seed);
    fill_n = (fill >= MAX_LEN) ? MAX_LEN : fill + 1'b1;
    // Only the low len_q bits of history and pattern take part in the compare.
    len_mask = '0;
    for (int i = 0; i < PAT_W; i++) begin
      len_mask[i] = (i < int'(len_q));
    end
    match = (fill_n >= len_q) && (((sr_n ^ pat_q) & len_mask) == '0);

    cfg_len_clamped = bus.cfg_len;
    if (bus.cfg_len == '0) begin
      cfg_len_clamped = LEN_W'(1);
    end else if (bus.cfg_len > MAX_LEN) begin
      cfg_len_clamped = MAX_LEN;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pat_q  <= DEF_PATTERN;
      len_q  <= RST_LEN;
      ovl_q  <= 1'b1;
      sr     <= '0;
      fill   <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else if (bus.cfg_load) begin
      // A load restarts collection and discards any bit presented with it.
      pat_q  <= bus.cfg_pattern;
      len_q  <= cfg_len_clamped;
      ovl_q  <= bus.cfg_overlap;
      fill   <= '0;
      done_q <= 1'b0;
      cnt_q  <= '0;
    end else if (bus.seed_valid) begin
      sr     <= sr_n;
      fill   <= (match && !ovl_q) ? '0 : fill_n;
      done_q <= match;
      if (bus.cnt_clr) begin
        cnt_q <= '0;
      end else if (match && cnt_q != CNT_MAX) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end else begin
      done_q <= 1'b0;
      if (bus.cnt_clr) begin
        cnt_q <= '0;
      end
    end
  end

  assign bus.o_done      = done_q;
  assign bus.o_match_cnt = cnt_q;
endmodule
